// File: rtl/mem2d_pkg.sv
// Shared definitions for the 2D memory engine: FSM state encoding and the
// (x,y) to flat-index mapping used by every address path.
package mem2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Flat index is {y,x} with x in the low bits.
  function automatic int unsigned flat_index(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned x_bits);
    return (y << x_bits) | x;
  endfunction

endpackage

// File: rtl/mem2d_ram.sv
// Storage array: one synchronous write port and one combinational read port
// whose result is always captured by a register in the engine.
module mem2d_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset: contents are undefined until written or cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem2d_engine.sv
// (x,y)-addressed memory with a registered read port, a fill (clear) engine
// and a raster-scan readout engine with a valid/ready handshake.
module mem2d_engine
  import mem2d_pkg::*;
#(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [X_BITS-1:0] wr_x,
  input  logic [Y_BITS-1:0] wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [X_BITS-1:0] rd_x,
  input  logic [Y_BITS-1:0] rd_y,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  input  logic              scan_start,
  output logic [DATA_W-1:0] scan_data,
  output logic [X_BITS-1:0] scan_x,
  output logic [Y_BITS-1:0] scan_y,
  output logic              scan_last,
  output logic              scan_valid,
  input  logic              scan_ready,
  output logic              busy
);

  localparam int ADDR_W = X_BITS + Y_BITS;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  logic [X_BITS-1:0] scan_x_q, scan_x_d;
  logic [Y_BITS-1:0] scan_y_q, scan_y_d;
  logic              scan_last_q, scan_last_d;
  logic              scan_valid_q, scan_valid_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_addr = ADDR_W'(flat_index(32'(wr_x), 32'(wr_y), X_BITS));
  assign rd_addr = ADDR_W'(flat_index(32'(rd_x), 32'(rd_y), X_BITS));

  mem2d_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Outside IDLE the engine pointer owns both RAM ports.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    scan_data_d  = scan_data_q;
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    scan_last_d  = scan_last_q;
    scan_valid_d = scan_valid_q;
    ram_we       = 1'b0;
    ram_waddr    = wr_addr;
    ram_wdata    = wr_data;
    ram_raddr    = (state_q == IDLE) ? rd_addr : ptr_q;

    unique case (state_q)
      IDLE: begin
        ram_we = wr_en;
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = ram_rdata;
        end
        if (clr_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
          fill_d  = clr_data;
        end else if (scan_start) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = fill_q;
        if (ptr_q == PTR_MAX) state_d = IDLE;
        else                  ptr_d   = ptr_q + ADDR_W'(1);
      end
      SCAN: begin
        if (!scan_valid_q || scan_ready) begin
          scan_data_d  = ram_rdata;
          scan_x_d     = ptr_q[X_BITS-1:0];
          scan_y_d     = ptr_q[ADDR_W-1:X_BITS];
          scan_valid_d = 1'b1;
          scan_last_d  = (ptr_q == PTR_MAX);
          if (ptr_q == PTR_MAX) state_d = DRAIN;
          else                  ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (scan_valid_q && scan_ready) begin
          scan_valid_d = 1'b0;
          scan_last_d  = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      fill_q       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      scan_data_q  <= '0;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      scan_last_q  <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      scan_data_q  <= scan_data_d;
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      scan_last_q  <= scan_last_d;
      scan_valid_q <= scan_valid_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign scan_data  = scan_data_q;
  assign scan_x     = scan_x_q;
  assign scan_y     = scan_y_q;
  assign scan_last  = scan_last_q;
  assign scan_valid = scan_valid_q;

endmodule

// File: tb/tb_mem2d_engine.sv
// Directed self-checking bench for mem2d_engine on a 4x4 byte array.
module tb_mem2d_engine;

  localparam int X_BITS = 2;
  localparam int Y_BITS = 2;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [X_BITS-1:0] wr_x;
  logic [Y_BITS-1:0] wr_y;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [X_BITS-1:0] rd_x;
  logic [Y_BITS-1:0] rd_y;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clr_start;
  logic [DATA_W-1:0] clr_data;
  logic              scan_start;
  logic [DATA_W-1:0] scan_data;
  logic [X_BITS-1:0] scan_x;
  logic [Y_BITS-1:0] scan_y;
  logic              scan_last;
  logic              scan_valid;
  logic              scan_ready;
  logic              busy;

  int testsRun = 0;
  int testsFailed = 0;

  mem2d_engine #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .scan_start(scan_start),
    .scan_data (scan_data),
    .scan_x    (scan_x),
    .scan_y    (scan_y),
    .scan_last (scan_last),
    .scan_valid(scan_valid),
    .scan_ready(scan_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input int wx, input int wy,
                               input int wd, input logic re, input int rx,
                               input int ry);
    wr_en   = we;
    wr_x    = X_BITS'(wx);
    wr_y    = Y_BITS'(wy);
    wr_data = DATA_W'(wd);
    rd_en   = re;
    rd_x    = X_BITS'(rx);
    rd_y    = Y_BITS'(ry);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Runs until busy drops, returns the number of busy cycles observed.
  task automatic countBusy(output int cycles, output int rdSeen);
    cycles = 0;
    rdSeen = 0;
    while (busy && cycles < 100) begin
      wr_en = 1'b1; wr_x = 0; wr_y = 0; wr_data = 8'hFF;
      rd_en = 1'b1; rd_x = 0; rd_y = 0;
      cycles++;
      tick();
      if (rd_valid) rdSeen++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // mode 0: ready tied high; mode 1: ready pattern 1,0,0 repeating.
  // abortAt >= 0 stops after that many accepted words without a further edge.
  task automatic runScan(input int mode, input int abortAt, output int words,
                         output int cycles, output int orderErr,
                         output int stableErr);
    logic        held;
    logic [14:0] heldVec;
    words = 0; cycles = 0; orderErr = 0; stableErr = 0; held = 1'b0;
    heldVec = '0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    while (words < 16 && cycles < 200) begin
      if (abortAt >= 0 && words == abortAt) break;
      scan_ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      if (held && heldVec != {scan_data, scan_x, scan_y, scan_last, scan_valid})
        stableErr++;
      held    = scan_valid && !scan_ready;
      heldVec = {scan_data, scan_x, scan_y, scan_last, scan_valid};
      if (scan_valid && scan_ready) begin
        if (scan_data != DATA_W'(words)) orderErr++;
        if (scan_x != X_BITS'(words % 4)) orderErr++;
        if (scan_y != Y_BITS'(words / 4)) orderErr++;
        if (scan_last != (words == 15)) orderErr++;
        words++;
      end
      tick();
      cycles++;
    end
    scan_ready = 1'b0;
  endtask

  initial begin
    int cyc, rdSeen, words, scanCyc, orderErr, stableErr, bad, seen;
    rst_n = 1'b0; wr_en = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    rd_en = 0; rd_x = 0; rd_y = 0; clr_start = 0; clr_data = 0;
    scan_start = 0; scan_ready = 0;
    #12;
    checkOutput("reset_rd_valid", 32'(rd_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_scan_valid", 32'(scan_valid), 0);
    rst_n = 1'b1;
    tick();

    applyStimulus(1, 3, 2, 8'hA5, 0, 0, 0);
    checkOutput("idle_rd_valid", 32'(rd_valid), 0);
    applyStimulus(0, 0, 0, 0, 1, 3, 2);
    checkOutput("read_valid", 32'(rd_valid), 1);
    checkOutput("read_data", 32'(rd_data), 32'hA5);
    tick();
    checkOutput("read_valid_pulse", 32'(rd_valid), 0);
    checkOutput("read_data_hold", 32'(rd_data), 32'hA5);

    applyStimulus(1, 1, 1, 8'h22, 0, 0, 0);
    applyStimulus(1, 1, 1, 8'h11, 1, 1, 1);
    checkOutput("read_first_old", 32'(rd_data), 32'h22);
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    checkOutput("read_after_write", 32'(rd_data), 32'h11);

    clr_data = 8'h5A; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    countBusy(cyc, rdSeen);
    checkOutput("clear_busy_cycles", 32'(cyc), 16);
    checkOutput("clear_rd_ignored", 32'(rdSeen), 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 1, i % 4, i / 4);
      if (rd_data != 8'h5A || !rd_valid) bad++;
    end
    checkOutput("clear_contents", 32'(bad), 0);

    for (int i = 0; i < 16; i++) applyStimulus(1, i % 4, i / 4, i, 0, 0, 0);
    runScan(0, -1, words, scanCyc, orderErr, stableErr);
    checkOutput("scan_words", 32'(words), 16);
    checkOutput("scan_order", 32'(orderErr), 0);
    checkOutput("scan_cycles", 32'(scanCyc), 17);
    checkOutput("scan_busy_done", 32'(busy), 0);
    checkOutput("scan_valid_done", 32'(scan_valid), 0);

    runScan(1, -1, words, scanCyc, orderErr, stableErr);
    checkOutput("bp_words", 32'(words), 16);
    checkOutput("bp_order", 32'(orderErr), 0);
    checkOutput("bp_stable", 32'(stableErr), 0);
    checkOutput("bp_busy_done", 32'(busy), 0);

    runScan(0, 7, words, scanCyc, orderErr, stableErr);
    checkOutput("abort_words", 32'(words), 7);
    checkOutput("abort_order", 32'(orderErr), 0);
    checkOutput("abort_pre_valid", 32'(scan_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_scan_valid", 32'(scan_valid), 0);
    checkOutput("abort_scan_data", 32'(scan_data), 0);
    checkOutput("abort_scan_xy", 32'({scan_x, scan_y}), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_rd_data", 32'(rd_data), 0);
    #2 rst_n = 1'b1;
    tick();
    runScan(0, -1, words, scanCyc, orderErr, stableErr);
    checkOutput("rescan_words", 32'(words), 16);
    checkOutput("rescan_order", 32'(orderErr), 0);

    clr_data = 8'h3C; clr_start = 1'b1; scan_start = 1'b1;
    tick();
    clr_start = 1'b0; scan_start = 1'b0;
    countBusy(cyc, rdSeen);
    checkOutput("both_busy_cycles", 32'(cyc), 16);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (scan_valid || busy) seen++;
    end
    checkOutput("both_no_scan", 32'(seen), 0);
    applyStimulus(0, 0, 0, 0, 1, 2, 3);
    checkOutput("both_cleared", 32'(rd_data), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
